// File: rtl/narrow_pipe_pkg.sv
// rtl/narrow_pipe_pkg.sv - shared widths and saturation constants for the narrowing pipe
package narrow_pipe_pkg;

  localparam int IN_W_DEF  = 32;
  localparam int OUT_W_DEF = 16;
  localparam int CNT_W_DEF = 16;

  // Saturation results for the default 16-bit output width
  localparam logic [15:0] SAT_POS_S = 16'h7FFF;
  localparam logic [15:0] SAT_NEG_S = 16'h8000;
  localparam logic [15:0] SAT_U     = 16'hFFFF;

endpackage

// File: rtl/narrow_range_chk.sv
// rtl/narrow_range_chk.sv - combinational 32->16 range check with saturate/truncate select
module narrow_range_chk
  import narrow_pipe_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [IN_W-1:0]  a,
  input  logic             sext,
  input  logic             sat_en,
  output logic [OUT_W-1:0] b,
  output logic             ovf
);

  localparam logic [OUT_W-1:0] SAT_MAX_U = '1;
  localparam logic [OUT_W-1:0] SAT_MAX_S = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN_S = {1'b1, {(OUT_W-1){1'b0}}};

  logic [IN_W-OUT_W-1:0] upper_u;
  logic [IN_W-OUT_W:0]   upper_s;
  logic                  fits;

  // Signed fit includes the output sign bit so the discarded bits must replicate it
  assign upper_u = a[IN_W-1:OUT_W];
  assign upper_s = a[IN_W-1:OUT_W-1];
  assign fits    = sext ? ((&upper_s) || !(|upper_s)) : !(|upper_u);

  always_comb begin
    ovf = !fits;
    b   = a[OUT_W-1:0];
    if (!fits && sat_en) begin
      if (!sext)
        b = SAT_MAX_U;
      else
        b = a[IN_W-1] ? SAT_MIN_S : SAT_MAX_S;
    end
  end

endmodule

// File: rtl/narrow_pipe.sv
// rtl/narrow_pipe.sv - two-stage valid/ready narrowing pipeline with overflow statistics
module narrow_pipe
  import narrow_pipe_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  a,
  input  logic             sext,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] b,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_stat
);

  logic             s1_valid;
  logic [IN_W-1:0]  s1_a;
  logic             s1_sext;
  logic             s1_sat_en;
  logic             s2_load;
  logic [OUT_W-1:0] chk_b;
  logic             chk_ovf;

  // Stage 2 frees up in the same cycle the consumer takes its word, so no bubble
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  narrow_range_chk #(.IN_W(IN_W), .OUT_W(OUT_W)) u_chk (
    .a      (s1_a),
    .sext   (s1_sext),
    .sat_en (s1_sat_en),
    .b      (chk_b),
    .ovf    (chk_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_sext   <= 1'b0;
      s1_sat_en <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a      <= a;
        s1_sext   <= sext;
        s1_sat_en <= sat_en;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      b         <= '0;
      ovf       <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        b   <= chk_b;
        ovf <= chk_ovf;
      end
    end
  end

  // Clear takes priority over a coincident overflow transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (clr_stat) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (out_valid && out_ready && ovf) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != {CNT_W{1'b1}})
        ovf_count <= ovf_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_narrow_pipe.sv
// tb/tb_narrow_pipe.sv - self-checking bench for narrow_pipe against a range-arithmetic model
module tb_narrow_pipe;
  import narrow_pipe_pkg::*;

  typedef struct packed {
    logic [15:0] b;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, sext, sat_en, out_ready, clr_stat;
  logic [31:0] a;
  logic        in_ready, out_valid, ovf, ovf_sticky;
  logic [15:0] b, ovf_count;
  logic        c2_in_ready, c2_out_valid, c2_ovf, c2_ovf_sticky;
  logic [15:0] c2_b;
  logic [1:0]  c2_ovf_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        q[$];
  int          m_cnt, m_cnt2;
  logic        m_sticky;
  logic        stalled_prev;
  logic [15:0] prev_b;
  logic        prev_ovf;
  logic        clr_on_ovf;
  logic        last_in_xfer;

  always #5 clk = ~clk;

  narrow_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .sext(sext), .sat_en(sat_en), .out_valid(out_valid), .out_ready(out_ready),
    .b(b), .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count), .clr_stat(clr_stat)
  );

  narrow_pipe #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c2_in_ready), .a(a),
    .sext(sext), .sat_en(sat_en), .out_valid(c2_out_valid), .out_ready(out_ready),
    .b(c2_b), .ovf(c2_ovf), .ovf_sticky(c2_ovf_sticky), .ovf_count(c2_ovf_count),
    .clr_stat(clr_stat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_narrow(input logic [31:0] x, input logic s, input logic sat);
    longint v;
    bit     fits;
    exp_t   r;
    if (s) begin
      v    = longint'($signed(x));
      fits = (v >= -32768) && (v <= 32767);
    end else begin
      v    = longint'(x);
      fits = (v <= 65535);
    end
    r.ovf = !fits;
    if (fits || !sat) r.b = x[15:0];
    else if (!s)      r.b = SAT_U;
    else              r.b = (v < 0) ? SAT_NEG_S : SAT_POS_S;
    return r;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    case ($urandom_range(3))
      0: w = 32'($urandom_range(0, 32767));
      1: w = {17'h1FFFF, 15'($urandom)};
      2: w = {16'h0000, 16'($urandom)};
      default: w = $urandom;
    endcase
    return w;
  endfunction

  // One clock: observe and score at negedge, then step past the rising edge
  task automatic cycle();
    exp_t e;
    logic xfer_out, xfer_ovf;
    @(negedge clk);
    chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
    chk("ovf_count_c2", 32'(c2_ovf_count), 32'(m_cnt2));
    chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
    chk("ovf_sticky_c2", 32'(c2_ovf_sticky), 32'(m_sticky));
    chk("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
    if (stalled_prev) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_b", 32'(b), 32'(prev_b));
      chk("stall_ovf", 32'(ovf), 32'(prev_ovf));
    end
    xfer_out = out_valid && out_ready;
    xfer_ovf = 1'b0;
    if (xfer_out) begin
      chk("out_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("b", 32'(b), 32'(e.b));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("c2_b", 32'(c2_b), 32'(e.b));
        xfer_ovf = e.ovf;
      end
    end
    if (xfer_ovf && clr_on_ovf) begin
      clr_stat   = 1'b1;
      clr_on_ovf = 1'b0;
    end
    if (clr_stat) begin
      m_cnt = 0; m_cnt2 = 0; m_sticky = 1'b0;
    end else if (xfer_ovf) begin
      m_sticky = 1'b1;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    last_in_xfer = in_valid && in_ready;
    if (last_in_xfer) q.push_back(ref_narrow(a, sext, sat_en));
    stalled_prev = out_valid && !out_ready;
    prev_b       = b;
    prev_ovf     = ovf;
    @(posedge clk);
    #1;
    clr_stat = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input logic s, input logic sat);
    in_valid = 1'b1; a = w; sext = s; sat_en = sat;
    last_in_xfer = 1'b0;
    for (int i = 0; i < 20 && !last_in_xfer; i++) cycle();
    chk("send_accepted", 32'(last_in_xfer), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; sext = 1'b0; sat_en = 1'b0;
    out_ready = 1'b1; clr_stat = 1'b0;
    m_cnt = 0; m_cnt2 = 0; m_sticky = 1'b0; stalled_prev = 1'b0;
    prev_b = '0; prev_ovf = 1'b0; clr_on_ovf = 1'b0; last_in_xfer = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_b", 32'(b), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency: word accepted, two edges later it is presented
    in_valid = 1'b1; a = 32'h0000_7FFF; sext = 1'b1; sat_en = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    chk("latency_b", 32'(b), 32'h7FFF);
    drain();

    send(32'h0000_8000, 1'b1, 1'b1);
    send(32'h0000_8000, 1'b0, 1'b1);
    send(32'h0000_8000, 1'b1, 1'b0);
    send(32'hFFFF_8000, 1'b1, 1'b1);
    send(32'hFFFF_7FFF, 1'b1, 1'b1);
    send(32'h0001_0000, 1'b0, 1'b1);
    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    drain();

    // Back-to-back stream with consumer pattern 1,0,0,1
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; a = rand_word(); sext = 1'($urandom); sat_en = 1'($urandom);
      last_in_xfer = 1'b0;
      for (int k = 0; k < 20 && !last_in_xfer; k++) begin
        out_ready = (k % 4 == 0) || (k % 4 == 3);
        cycle();
      end
      chk("stream_accepted", 32'(last_in_xfer), 32'd1);
    end
    drain();

    // Randomised flow including occasional stat clears
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(3) != 0);
      clr_stat  = ($urandom_range(40) == 0);
      a = rand_word(); sext = 1'($urandom); sat_en = 1'($urandom);
      cycle();
    end
    drain();

    // Counter saturation on the 2-bit instance, then clear coinciding with an overflow transfer
    clr_stat = 1'b1;
    cycle();
    for (int i = 0; i < 5; i++) send(32'h0001_0000, 1'b0, 1'b1);
    drain();
    cycle();
    chk("c2_count_sat", 32'(c2_ovf_count), 32'd3);
    chk("c2_sticky_set", 32'(c2_ovf_sticky), 32'd1);
    chk("count16_five", 32'(ovf_count), 32'd5);
    clr_on_ovf = 1'b1;
    send(32'h0001_0000, 1'b0, 1'b1);
    drain();
    cycle();
    chk("clr_wins_count", 32'(c2_ovf_count), 32'd0);
    chk("clr_wins_sticky", 32'(c2_ovf_sticky), 32'd0);
    chk("clr_wins_count16", 32'(ovf_count), 32'd0);

    // Asynchronous reset with results held in a stalled pipe
    send(32'h8000_0000, 1'b1, 1'b1);
    out_ready = 1'b0;
    send(32'h0002_0000, 1'b0, 1'b0);
    cycle();
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_b", 32'(b), 32'd0);
    chk("async_rst_ovf", 32'(ovf), 32'd0);
    chk("async_rst_sticky", 32'(ovf_sticky), 32'd0);
    chk("async_rst_count", 32'(ovf_count), 32'd0);
    q.delete();
    m_cnt = 0; m_cnt2 = 0; m_sticky = 1'b0; stalled_prev = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    send(32'h0000_1234, 1'b0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
